// File: rtl/sy_l2_tl_arb.sv
// sy_l2_tl_arb: arbitrates NUM_CLIENTS TileLink-UL requesters onto the single L2 A channel
// and routes L2 D-channel responses back to the owning client by source ID.
// Multi-beat Put bursts stay atomic; each client is limited to MAX_OUTST outstanding requests.
// Build option: define SY_L2_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins)
// instead of round-robin.

package tl_pkg;
   localparam int unsigned SizeW = 3;
   localparam int unsigned SrcW  = 8;

   localparam logic [2:0] OpPutFullData    = 3'd0;
   localparam logic [2:0] OpPutPartialData = 3'd1;
   localparam logic [2:0] OpGet            = 3'd4;
   localparam logic [2:0] OpAccessAck      = 3'd0;
   localparam logic [2:0] OpAccessAckData  = 3'd1;

   typedef struct packed {
      logic [2:0]       opcode;
      logic [2:0]       param;
      logic [SizeW-1:0] size;
      logic [SrcW-1:0]  source;
      logic [31:0]      address;
      logic [7:0]       mask;
      logic [63:0]      data;
      logic             corrupt;
   } A_chan_bits_t;

   typedef struct packed {
      logic [2:0]       opcode;
      logic [1:0]       param;
      logic [SizeW-1:0] size;
      logic [SrcW-1:0]  source;
      logic             sink;
      logic             denied;
      logic [63:0]      data;
      logic             corrupt;
   } D_chan_bits_t;
endpackage

module sy_l2_tl_arb #(
   parameter int unsigned NUM_CLIENTS = 2,
   parameter int unsigned BEAT_BYTES  = 8,
   parameter int unsigned SRC_LSB     = 4,
   parameter int unsigned MAX_OUTST   = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_CLIENTS-1:0]          cli_A_valid_i,
   output logic [NUM_CLIENTS-1:0]          cli_A_ready_o,
   input  tl_pkg::A_chan_bits_t            cli_A_bits_i [NUM_CLIENTS],
   output logic [NUM_CLIENTS-1:0]          cli_D_valid_o,
   input  logic [NUM_CLIENTS-1:0]          cli_D_ready_i,
   output tl_pkg::D_chan_bits_t            cli_D_bits_o,
   output logic                            l2_A_valid_o,
   input  logic                            l2_A_ready_i,
   output tl_pkg::A_chan_bits_t            l2_A_bits_o,
   input  logic                            l2_D_valid_i,
   output logic                            l2_D_ready_o,
   input  tl_pkg::D_chan_bits_t            l2_D_bits_i
);

   localparam int unsigned IDX_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned BEAT_W = 8;
   localparam int unsigned LOG_BB = $clog2(BEAT_BYTES);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   // Beats remaining after the first one for a transfer of 2^sz bytes.
   function automatic logic [BEAT_W-1:0] beats_m1(input logic [tl_pkg::SizeW-1:0] sz);
      int unsigned s;
      s = 32'(sz);
      if (s > LOG_BB) begin
         return BEAT_W'((32'd1 << (s - LOG_BB)) - 32'd1);
      end
      return '0;
   endfunction

   state_e                       state_q, state_d;
   logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]             outst_cnt_q [NUM_CLIENTS];
   logic [CNT_W-1:0]             outst_cnt_d [NUM_CLIENTS];
   logic [BEAT_W-1:0]            a_beat_cnt_q, a_beat_cnt_d;
   logic [BEAT_W-1:0]            d_beat_cnt_q, d_beat_cnt_d;
   logic [IDX_W-1:0]             burst_idx_q, burst_idx_d;
   logic                         hold_q, hold_d;
   logic [IDX_W-1:0]             hold_idx_q, hold_idx_d;

   logic [NUM_CLIENTS-1:0]       eligible;
   logic                         pick_found;
   logic [IDX_W-1:0]             pick_idx;
   logic [IDX_W-1:0]             sel;
   logic                         a_req;
   logic                         a_hs;
   logic                         a_first_hs;
   tl_pkg::A_chan_bits_t         sel_bits;
   logic                         put_burst;

   logic [tl_pkg::SrcW-1:0]      dst;
   logic                         dst_ok;
   logic                         d_hs;
   logic                         d_last;
   logic                         d_last_hs;
   logic                         data_burst;

   // A client may compete only while it has request credit left.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         eligible[i] = cli_A_valid_i[i] && (outst_cnt_q[i] < CNT_W'(MAX_OUTST));
      end
   end

   // Arbitration pick among eligible clients.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
`ifdef SY_L2_ARB_FIXED_PRIO_EN
      for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
         if (!pick_found && eligible[IDX_W'(k)]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(k);
         end
      end
`else
      for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
         int unsigned idx;
         idx = 32'(rr_ptr_q) + k;
         if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
         if (!pick_found && eligible[IDX_W'(idx)]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(idx);
         end
      end
`endif
   end

   // Effective selection: burst owner, then a stalled grant, else the fresh pick.
   always_comb begin
      sel   = pick_idx;
      a_req = pick_found;
      if (state_q == StBurst) begin
         sel   = burst_idx_q;
         a_req = cli_A_valid_i[burst_idx_q];
      end else if (hold_q) begin
         sel   = hold_idx_q;
         a_req = cli_A_valid_i[hold_idx_q];
      end
      if (rst_i) begin
         a_req = 1'b0;
      end
   end

   assign sel_bits  = cli_A_bits_i[sel];
   assign a_hs      = a_req && l2_A_ready_i;
   assign put_burst = ((sel_bits.opcode == tl_pkg::OpPutFullData) ||
                       (sel_bits.opcode == tl_pkg::OpPutPartialData)) &&
                      (32'(sel_bits.size) > LOG_BB);

   // A-channel mux and ready steering; outputs are forced to zero while in reset.
   always_comb begin
      l2_A_valid_o  = a_req;
      l2_A_bits_o   = a_req ? sel_bits : '0;
      cli_A_ready_o = '0;
      if (a_req) begin
         cli_A_ready_o[sel] = l2_A_ready_i;
      end
   end

   // Arbiter FSM next state: burst tracking, grant hold and round-robin pointer.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      a_beat_cnt_d = a_beat_cnt_q;
      burst_idx_d  = burst_idx_q;
      hold_d       = hold_q;
      hold_idx_d   = hold_idx_q;
      a_first_hs   = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Lock the grant while the L2 back-pressures a presented request.
            hold_d     = a_req && !l2_A_ready_i;
            hold_idx_d = sel;
            if (a_hs) begin
               a_first_hs = 1'b1;
`ifndef SY_L2_ARB_FIXED_PRIO_EN
               rr_ptr_d = (32'(sel) == NUM_CLIENTS - 1) ? '0 : sel + 1'b1;
`endif
               if (put_burst) begin
                  a_beat_cnt_d = beats_m1(sel_bits.size);
                  burst_idx_d  = sel;
                  state_d      = StBurst;
               end
            end
         end
         StBurst: begin
            hold_d = 1'b0;
            if (a_hs) begin
               a_beat_cnt_d = a_beat_cnt_q - 1'b1;
               if (a_beat_cnt_q == BEAT_W'(1)) begin
                  state_d = StIdle;
               end
            end
         end
      endcase
   end

   assign dst    = l2_D_bits_i.source >> SRC_LSB;
   assign dst_ok = 32'(dst) < NUM_CLIENTS;

   // D routing by source; responses for nonexistent clients are sunk.
   always_comb begin
      cli_D_valid_o = '0;
      l2_D_ready_o  = 1'b1;
      if (dst_ok) begin
         cli_D_valid_o[dst[IDX_W-1:0]] = l2_D_valid_i;
         l2_D_ready_o                  = cli_D_ready_i[dst[IDX_W-1:0]];
      end
      if (rst_i) begin
         cli_D_valid_o = '0;
         l2_D_ready_o  = 1'b0;
      end
   end

   assign cli_D_bits_o = rst_i ? '0 : l2_D_bits_i;
   assign d_hs         = l2_D_valid_i && l2_D_ready_o;
   assign data_burst   = (l2_D_bits_i.opcode == tl_pkg::OpAccessAckData) &&
                         (32'(l2_D_bits_i.size) > LOG_BB);

   // D beat counter: detects the final beat of each (contiguous) response.
   always_comb begin
      d_beat_cnt_d = d_beat_cnt_q;
      d_last       = 1'b1;
      if (d_beat_cnt_q != '0) begin
         d_last = (d_beat_cnt_q == BEAT_W'(1));
      end else if (data_burst) begin
         d_last = 1'b0;
      end
      if (d_hs) begin
         if (d_beat_cnt_q != '0) begin
            d_beat_cnt_d = d_beat_cnt_q - 1'b1;
         end else if (data_burst) begin
            d_beat_cnt_d = beats_m1(l2_D_bits_i.size);
         end
      end
   end

   assign d_last_hs = d_hs && d_last && dst_ok;

   // Outstanding counters: +1 on first A beat, -1 on last D beat, both cancel.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         logic inc;
         logic dec;
         inc = a_first_hs && (32'(sel) == i);
         dec = d_last_hs && (32'(dst) == i);
         outst_cnt_d[i] = outst_cnt_q[i];
         if (inc && !dec) begin
            outst_cnt_d[i] = outst_cnt_q[i] + 1'b1;
         end else if (dec && !inc && (outst_cnt_q[i] != '0)) begin
            outst_cnt_d[i] = outst_cnt_q[i] - 1'b1;
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         a_beat_cnt_q <= '0;
         d_beat_cnt_q <= '0;
         burst_idx_q  <= '0;
         hold_q       <= 1'b0;
         hold_idx_q   <= '0;
         for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            outst_cnt_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         a_beat_cnt_q <= a_beat_cnt_d;
         d_beat_cnt_q <= d_beat_cnt_d;
         burst_idx_q  <= burst_idx_d;
         hold_q       <= hold_d;
         hold_idx_q   <= hold_idx_d;
         for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            outst_cnt_q[i] <= outst_cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_sy_l2_tl_arb.sv
// Directed bench for sy_l2_tl_arb (2 clients, 8-byte beats, SRC_LSB=4, MAX_OUTST=4).
// Inputs change on the falling edge; outputs are sampled 1ns later, clear of the rising edge.
module tb_sy_l2_tl_arb;
   import tl_pkg::*;

   localparam int unsigned N = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         a_valid, a_ready, d_valid, d_ready;
   A_chan_bits_t         a_bits [N];
   D_chan_bits_t         cli_d_bits, l2_d_bits;
   A_chan_bits_t         l2_a_bits;
   logic                 l2_a_valid, l2_a_ready, l2_d_valid, l2_d_ready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sy_l2_tl_arb #(
      .NUM_CLIENTS(N),
      .BEAT_BYTES (8),
      .SRC_LSB    (4),
      .MAX_OUTST  (4)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cli_A_valid_i(a_valid),
      .cli_A_ready_o(a_ready),
      .cli_A_bits_i (a_bits),
      .cli_D_valid_o(d_valid),
      .cli_D_ready_i(d_ready),
      .cli_D_bits_o (cli_d_bits),
      .l2_A_valid_o (l2_a_valid),
      .l2_A_ready_i (l2_a_ready),
      .l2_A_bits_o  (l2_a_bits),
      .l2_D_valid_i (l2_d_valid),
      .l2_D_ready_o (l2_d_ready),
      .l2_D_bits_i  (l2_d_bits)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic A_chan_bits_t mk_a(input logic [2:0] op, input logic [2:0] sz,
                                         input logic [7:0] src);
      A_chan_bits_t b;
      b         = '0;
      b.opcode  = op;
      b.size    = sz;
      b.source  = src;
      b.address = 32'h0000_1000;
      b.mask    = 8'hFF;
      b.data    = 64'hA5A5_0000_0000_0000 | 64'(src);
      return b;
   endfunction

   function automatic D_chan_bits_t mk_d(input logic [2:0] op, input logic [2:0] sz,
                                         input logic [7:0] src);
      D_chan_bits_t b;
      b        = '0;
      b.opcode = op;
      b.size   = sz;
      b.source = src;
      b.data   = 64'h5A5A_0000_0000_0000 | 64'(src);
      return b;
   endfunction

   task automatic clear_inputs();
      a_valid    = '0;
      a_bits[0]  = '0;
      a_bits[1]  = '0;
      d_ready    = '0;
      l2_a_ready = 1'b0;
      l2_d_valid = 1'b0;
      l2_d_bits  = '0;
   endtask

   // Entered and left on a falling edge.
   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [1:0] exp;

      // Reset state
      rst = 1'b1;
      clear_inputs();
      d_ready = 2'b11;
      #1;
      check("rst_l2a_valid", 128'(l2_a_valid), 128'(1'b0));
      check("rst_cli_ready", 128'(a_ready), 128'(2'b00));
      check("rst_l2d_ready", 128'(l2_d_ready), 128'(1'b0));
      check("rst_cli_dvalid", 128'(d_valid), 128'(2'b00));
      check("rst_l2a_bits", 128'(l2_a_bits), 128'(0));
      @(negedge clk);
      rst = 1'b0;

      // Both clients stream Gets; grants alternate (fixed priority: client0 always)
      do_reset();
      l2_a_ready = 1'b1;
      a_bits[0]  = mk_a(OpGet, 3'd3, 8'h01);
      a_bits[1]  = mk_a(OpGet, 3'd3, 8'h11);
      a_valid    = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
`ifdef SY_L2_ARB_FIXED_PRIO_EN
         exp = 2'b01;
`else
         exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
         check("rr_grant", 128'(a_ready), 128'(exp));
         @(negedge clk);
      end

      // 8-beat Put from client1 stays atomic while client0 waits
      do_reset();
      l2_a_ready = 1'b1;
      a_bits[1]  = mk_a(OpPutFullData, 3'd6, 8'h11);
      a_valid    = 2'b10;
      #1;
      check("burst_first", 128'({l2_a_bits.source, a_ready}), 128'({8'h11, 2'b10}));
      @(negedge clk);
      a_bits[0] = mk_a(OpGet, 3'd3, 8'h01);
      a_valid   = 2'b11;
      for (int i = 1; i < 8; i++) begin
         #1;
         check("burst_beat", 128'({l2_a_bits.source, a_ready}), 128'({8'h11, 2'b10}));
         @(negedge clk);
      end
      #1;
      check("after_burst", 128'({l2_a_bits.source, a_ready}), 128'({8'h01, 2'b01}));
      @(negedge clk);

      // Back-pressure: client1's grant is held even after client0 becomes valid
      do_reset();
      a_bits[0] = mk_a(OpGet, 3'd3, 8'h01);
      a_bits[1] = mk_a(OpGet, 3'd3, 8'h11);
      a_valid   = 2'b10;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) a_valid = 2'b11;
         #1;
         check("hold_sel", 128'({l2_a_valid, l2_a_bits.source, a_ready}),
               128'({1'b1, 8'h11, 2'b00}));
         @(negedge clk);
      end
      l2_a_ready = 1'b1;
      #1;
      check("hold_accept", 128'(a_ready), 128'(2'b10));
      @(negedge clk);
      #1;
      check("hold_next", 128'(a_ready), 128'(2'b01));
      @(negedge clk);

      // Outstanding limit: 4 Gets, 5th blocked until an 8-beat AccessAckData completes
      do_reset();
      l2_a_ready = 1'b1;
      a_bits[0]  = mk_a(OpGet, 3'd6, 8'h02);
      a_valid    = 2'b01;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("outst_grant", 128'(a_ready), 128'(2'b01));
         @(negedge clk);
      end
      #1;
      check("outst_block", 128'({l2_a_valid, a_ready}), 128'(3'b000));
      @(negedge clk);
      d_ready    = 2'b11;
      l2_d_valid = 1'b1;
      l2_d_bits  = mk_d(OpAccessAckData, 3'd6, 8'h02);
      for (int i = 0; i < 8; i++) begin
         #1;
         check("outst_block_d", 128'(a_ready), 128'(2'b00));
         if (i == 0) check("d_route0", 128'({l2_d_ready, d_valid}), 128'({1'b1, 2'b01}));
         @(negedge clk);
      end
      l2_d_valid = 1'b0;
      #1;
      check("outst_release", 128'(a_ready), 128'(2'b01));
      @(negedge clk);

      // D routing: source 0x13 goes to client1, stalls on its ready; 0x7F is sunk
      do_reset();
      d_ready    = 2'b01;
      l2_d_valid = 1'b1;
      l2_d_bits  = mk_d(OpAccessAck, 3'd3, 8'h13);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("d_stall", 128'({l2_d_ready, d_valid}), 128'({1'b0, 2'b10}));
         @(negedge clk);
      end
      d_ready = 2'b11;
      #1;
      check("d_accept", 128'({l2_d_ready, d_valid, cli_d_bits.source}),
            128'({1'b1, 2'b10, 8'h13}));
      @(negedge clk);
      l2_d_bits = mk_d(OpAccessAck, 3'd3, 8'h7F);
      #1;
      check("d_drop", 128'({l2_d_ready, d_valid}), 128'({1'b1, 2'b00}));
      @(negedge clk);
      l2_d_valid = 1'b0;
      a_bits[1]  = mk_a(OpGet, 3'd3, 8'h11);
      a_valid    = 2'b10;
      l2_a_ready = 1'b1;
      #1;
      check("no_underflow", 128'(a_ready), 128'(2'b10));
      @(negedge clk);

      // Reset on the 3rd beat of an 8-beat Put
      do_reset();
      l2_a_ready = 1'b1;
      a_bits[0]  = mk_a(OpPutFullData, 3'd6, 8'h01);
      a_valid    = 2'b01;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_ctl", 128'({l2_a_valid, a_ready, d_valid, l2_d_ready}), 128'(0));
      check("rst_mid_bits", 128'(l2_a_bits), 128'(0));
      @(negedge clk);
      rst       = 1'b0;
      a_bits[1] = mk_a(OpGet, 3'd3, 8'h11);
      a_valid   = 2'b10;
      #1;
      check("post_rst_idle", 128'({l2_a_bits.source, a_ready}), 128'({8'h11, 2'b10}));
      @(negedge clk);
      a_bits[0] = mk_a(OpGet, 3'd3, 8'h01);
      a_valid   = 2'b01;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("post_rst_cnt", 128'(a_ready), 128'(2'b01));
         @(negedge clk);
      end
      #1;
      check("post_rst_block", 128'(a_ready), 128'(2'b00));
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
